// File: rtl/pipe_pkg.sv
// pipe_pkg: control struct and constants shared by the pipeline registers and forwarding unit
package pipe_pkg;
   typedef struct packed {
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       MemtoReg;
      logic       ALUSrc;
      logic [1:0] ALUOp;
      logic [3:0] funct;
   } idex_ctrl_t;
   localparam logic [1:0] ALUOP_ITYPE   = 2'b11;
   localparam logic [4:0] REG_X0        = 5'd0;
   localparam idex_ctrl_t IDEX_CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: raw load-use hazard between the ID instruction and a load sitting in EX
module load_use_detect
   import pipe_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [1:0] id_aluop,
   input  logic       ex_valid,
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   output logic       hazard
);
   // I-type instructions carry immediate bits in the rs2 field, so rs2 is not a real source
   assign hazard = id_valid && ex_valid && ex_memread && ex_rd != REG_X0 &&
                   (ex_rd == id_rs1 || (id_aluop != ALUOP_ITYPE && ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, flush squash and hold.
// Define IDEX_WB_BYPASS_EN to capture same-cycle write-back data on operand load.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  idex_ctrl_t      id_ctrl,
   input  logic            ex_flush,
   input  logic            ex_hold,
   input  logic            wb_RegWrite,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            idex_valid,
   output logic [XLEN-1:0] idex_pc,
   output logic [XLEN-1:0] idex_rs1_data,
   output logic [XLEN-1:0] idex_rs2_data,
   output logic [XLEN-1:0] idex_imm,
   output logic [4:0]      idex_rs1,
   output logic [4:0]      idex_rs2,
   output logic [4:0]      idex_rd,
   output idex_ctrl_t      idex_ctrl,
   output logic            hazard_stall,
   output logic            id_ready
);
   logic            r_valid;
   logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
   logic [4:0]      r_rs1, r_rs2, r_rd;
   idex_ctrl_t      r_ctrl;
   logic            w_hazard;
   logic [XLEN-1:0] w_rs1_data, w_rs2_data;

   load_use_detect u_lud (
      .id_valid   (id_valid),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_aluop   (id_ctrl.ALUOp),
      .ex_valid   (r_valid),
      .ex_memread (r_ctrl.MemRead),
      .ex_rd      (r_rd),
      .hazard     (w_hazard)
   );

   assign hazard_stall = w_hazard && !ex_flush && !ex_hold;
   assign id_ready     = !hazard_stall && !ex_hold;

`ifdef IDEX_WB_BYPASS_EN
   assign w_rs1_data = (wb_RegWrite && wb_rd != REG_X0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
   assign w_rs2_data = (wb_RegWrite && wb_rd != REG_X0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
`else
   logic w_unused;
   assign w_unused   = ^{wb_RegWrite, wb_rd, wb_data};
   assign w_rs1_data = id_rs1_data;
   assign w_rs2_data = id_rs2_data;
`endif

   // flush outranks hold so a squashed instruction never survives a stall
   always_ff @(posedge clk) begin
      if (!rst_n || ex_flush || hazard_stall) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_ctrl     <= IDEX_CTRL_NOP;
      end else if (!ex_hold) begin
         r_valid    <= id_valid;
         r_pc       <= id_pc;
         r_rs1_data <= w_rs1_data;
         r_rs2_data <= w_rs2_data;
         r_imm      <= id_imm;
         r_rs1      <= id_rs1;
         r_rs2      <= id_rs2;
         r_rd       <= id_rd;
         r_ctrl     <= id_valid ? id_ctrl : IDEX_CTRL_NOP;
      end
   end

   assign idex_valid    = r_valid;
   assign idex_pc       = r_pc;
   assign idex_rs1_data = r_rs1_data;
   assign idex_rs2_data = r_rs2_data;
   assign idex_imm      = r_imm;
   assign idex_rs1      = r_rs1;
   assign idex_rs2      = r_rs2;
   assign idex_rd       = r_rd;
   assign idex_ctrl     = r_ctrl;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors for id_ex_stage; bypass expectations follow IDEX_WB_BYPASS_EN
module tb_id_ex_stage;
   import pipe_pkg::*;
   localparam idex_ctrl_t C_LD   = 11'b11011_00_0010;
   localparam idex_ctrl_t C_ADD  = 11'b10000_10_0000;
   localparam idex_ctrl_t C_ADDI = 11'b10001_11_0000;

   logic        clk = 1'b0;
   logic        rst_n, id_valid, ex_flush, ex_hold, wb_RegWrite;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
   idex_ctrl_t  id_ctrl, idex_ctrl;
   logic        idex_valid, hazard_stall, id_ready;
   logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
   logic [4:0]  idex_rs1, idex_rs2, idex_rd;
   int          n_tests = 0, n_fail = 0;

   id_ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .ex_flush(ex_flush), .ex_hold(ex_hold),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
      .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rs1(idex_rs1),
      .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_ctrl(idex_ctrl),
      .hazard_stall(hazard_stall), .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input idex_ctrl_t c);
      id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = c;
      id_rs1_data = pc + 32'h11; id_rs2_data = pc + 32'h22; id_imm = pc + 32'h33;
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ex_flush = 1'b0; ex_hold = 1'b0;
      wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_data = '0;
      set_id(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, C_ADD);
      step();
      check("rst_valid", idex_valid, 0);
      check("rst_pc", idex_pc, 0);
      check("rst_ctrl", idex_ctrl, 0);
      check("rst_rd", idex_rd, 0);
      check("rst_stall", hazard_stall, 0);
      check("rst_ready", id_ready, 1);
      rst_n = 1'b1;
      // load x5 then dependent add
      set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, C_LD);
      check("ld_nostall", hazard_stall, 0);
      step();
      check("ld_valid", idex_valid, 1);
      check("ld_rd", idex_rd, 5);
      check("ld_ctrl", idex_ctrl, C_LD);
      check("ld_pc", idex_pc, 32'h100);
      check("ld_rs1d", idex_rs1_data, 32'h111);
      check("ld_imm", idex_imm, 32'h133);
      set_id(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, C_ADD);
      check("add_stall", hazard_stall, 1);
      check("add_ready", id_ready, 0);
      step();
      check("bub_valid", idex_valid, 0);
      check("bub_ctrl", idex_ctrl, 0);
      check("bub_stall", hazard_stall, 0);
      check("bub_ready", id_ready, 1);
      step();
      check("add_valid", idex_valid, 1);
      check("add_rs1", idex_rs1, 5);
      check("add_pc", idex_pc, 32'h104);
      // load x5 then addi x6,x5,4
      set_id(1'b1, 32'h108, 5'd1, 5'd2, 5'd5, C_LD);
      step();
      set_id(1'b1, 32'h10c, 5'd5, 5'd4, 5'd6, C_ADDI);
      check("addi_stall", hazard_stall, 1);
      step();
      check("addi_bub", idex_valid, 0);
      step();
      check("addi_in", idex_pc, 32'h10c);
      // load x5 then I-type with rs2 field 5
      set_id(1'b1, 32'h110, 5'd1, 5'd2, 5'd5, C_LD);
      step();
      set_id(1'b1, 32'h114, 5'd3, 5'd5, 5'd6, C_ADDI);
      check("itype_rs2", hazard_stall, 0);
      // same with R-type: rs2 compares
      set_id(1'b1, 32'h114, 5'd3, 5'd5, 5'd6, C_ADD);
      check("rtype_rs2", hazard_stall, 1);
      // ex_hold masks the stall
      ex_hold = 1'b1; #1;
      check("hold_mask", hazard_stall, 0);
      check("hold_ready", id_ready, 0);
      ex_hold = 1'b0;
      // invalid ID instruction never stalls, and loads a bubble
      set_id(1'b0, 32'h118, 5'd5, 5'd5, 5'd6, C_ADD);
      check("inv_stall", hazard_stall, 0);
      step();
      check("inv_valid", idex_valid, 0);
      check("inv_ctrl", idex_ctrl, 0);
      check("inv_pc", idex_pc, 32'h118);
      // load x0 then use x0
      set_id(1'b1, 32'h120, 5'd1, 5'd2, 5'd0, C_LD);
      step();
      set_id(1'b1, 32'h124, 5'd0, 5'd0, 5'd6, C_ADD);
      check("x0_stall", hazard_stall, 0);
      // non-load write to x5 then use
      set_id(1'b1, 32'h128, 5'd1, 5'd2, 5'd5, C_ADD);
      step();
      set_id(1'b1, 32'h12c, 5'd5, 5'd5, 5'd6, C_ADD);
      check("alu_stall", hazard_stall, 0);
      // flush with load-use present
      set_id(1'b1, 32'h130, 5'd1, 5'd2, 5'd5, C_LD);
      step();
      set_id(1'b1, 32'h134, 5'd5, 5'd7, 5'd6, C_ADD);
      ex_flush = 1'b1; #1;
      check("fl_stall", hazard_stall, 0);
      step();
      ex_flush = 1'b0;
      check("fl_valid", idex_valid, 0);
      check("fl_ctrl", idex_ctrl, 0);
      check("fl_pc", idex_pc, 0);
      // hold three cycles with ID changing
      set_id(1'b1, 32'h200, 5'd1, 5'd2, 5'd8, C_ADD);
      step();
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1'b1, 32'h300 + 32'(4 * i), 5'd9, 5'd10, 5'd11, C_ADDI);
         check("hold_rdy", id_ready, 0);
         step();
         check("hold_pc", idex_pc, 32'h200);
         check("hold_rd", idex_rd, 8);
      end
      ex_hold = 1'b0; #1;
      check("rel_ready", id_ready, 1);
      step();
      check("rel_pc", idex_pc, 32'h308);
      check("rel_ctrl", idex_ctrl, C_ADDI);
      // flush and hold together: flush wins
      ex_hold = 1'b1; ex_flush = 1'b1;
      step();
      ex_hold = 1'b0; ex_flush = 1'b0;
      check("flhold_valid", idex_valid, 0);
      check("flhold_ctrl", idex_ctrl, 0);
      // reset during a stall
      set_id(1'b1, 32'h400, 5'd1, 5'd2, 5'd5, C_LD);
      step();
      set_id(1'b1, 32'h404, 5'd5, 5'd7, 5'd6, C_ADD);
      check("pre_rst_stall", hazard_stall, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; #1;
      check("mid_rst_valid", idex_valid, 0);
      check("mid_rst_stall", hazard_stall, 0);
      step();
      check("post_rst_pc", idex_pc, 32'h404);
      check("post_rst_valid", idex_valid, 1);
      // write-back bypass
      set_id(1'b1, 32'h500, 5'd1, 5'd9, 5'd6, C_ADD);
      id_rs2_data = 32'h0; wb_RegWrite = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
      step();
`ifdef IDEX_WB_BYPASS_EN
      check("byp_rs2", idex_rs2_data, 32'hDEADBEEF);
`else
      check("byp_rs2", idex_rs2_data, 32'h0);
`endif
      check("byp_rs1", idex_rs1_data, 32'h511);
      wb_rd = 5'd0;
      step();
      check("byp_x0", idex_rs2_data, 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
